// File: rtl/sextium_ctrl_gen.sv
// Sextium III next-generation control unit: fetches a word of SLOTS packed opcodes
// and sequences them slot by slot with memory/IO ready handshakes and early refetch.
module sextium_ctrl_gen #(
    parameter int unsigned SLOTS  = 4,
    parameter int unsigned SLOT_W = $clog2(SLOTS),
    parameter int unsigned INSN_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [INSN_W-1:0] insn,
    input  logic              accz,
    input  logic              accn,
    input  logic [1:0]        acc_sys,
    input  logic              mem_ready,
    input  logic              io_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic              io_read,
    output logic              io_write,
    output logic              ir_write,
    output logic              ip_write,
    output logic              acc_write,
    output logic              seladdr,
    output logic [1:0]        selacc,
    output logic              selswap,
    output logic              doswap,
    output logic              selip1,
    output logic              selip2,
    output logic [1:0]        aluinsn,
    output logic [SLOT_W-1:0] curinsn,
    output logic              halted,
    output logic              illegal
);

    localparam logic [INSN_W-1:0] OP_NOP     = INSN_W'(0);
    localparam logic [INSN_W-1:0] OP_SYSCALL = INSN_W'(1);
    localparam logic [INSN_W-1:0] OP_LOAD    = INSN_W'(2);
    localparam logic [INSN_W-1:0] OP_STORE   = INSN_W'(3);
    localparam logic [INSN_W-1:0] OP_SWAPA   = INSN_W'(4);
    localparam logic [INSN_W-1:0] OP_SWAPD   = INSN_W'(5);
    localparam logic [INSN_W-1:0] OP_BRANCHZ = INSN_W'(6);
    localparam logic [INSN_W-1:0] OP_BRANCHN = INSN_W'(7);
    localparam logic [INSN_W-1:0] OP_JUMP    = INSN_W'(8);
    localparam logic [INSN_W-1:0] OP_CONST   = INSN_W'(9);
    localparam logic [INSN_W-1:0] OP_ADD     = INSN_W'(10);
    localparam logic [INSN_W-1:0] OP_SUB     = INSN_W'(11);
    localparam logic [INSN_W-1:0] OP_MUL     = INSN_W'(12);
    localparam logic [INSN_W-1:0] OP_DIV     = INSN_W'(13);

    typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_HALTED} state_t;

    state_t              r_state, w_state_nx;
    logic                r_mem_read, r_mem_write, r_io_read, r_io_write;
    logic                r_ir_we, r_ip_we, r_acc_we;
    logic                r_seladdr, r_selswap, r_doswap, r_selip1, r_selip2;
    logic [1:0]          r_selacc, r_aluinsn;
    logic [SLOT_W-1:0]   r_curinsn;
    logic                r_halted, r_illegal;
    logic                r_wait_mem, r_wait_io, r_xfer, r_halt_req;

    logic                w_mem_read_nx, w_mem_write_nx, w_io_read_nx, w_io_write_nx;
    logic                w_ir_we_nx, w_ip_we_nx, w_acc_we_nx;
    logic                w_seladdr_nx, w_selswap_nx, w_doswap_nx, w_selip1_nx, w_selip2_nx;
    logic [1:0]          w_selacc_nx, w_aluinsn_nx;
    logic [SLOT_W-1:0]   w_curinsn_nx;
    logic                w_halted_nx, w_illegal_nx;
    logic                w_wait_mem_nx, w_wait_io_nx, w_xfer_nx, w_halt_req_nx;
    logic                w_go;

    // The pending access (if any) completes this cycle; enables fire only then.
    assign w_go = (!r_wait_mem || mem_ready) && (!r_wait_io || io_ready);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= S_FETCH;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_io_read   <= 1'b0;
            r_io_write  <= 1'b0;
            r_ir_we     <= 1'b0;
            r_ip_we     <= 1'b0;
            r_acc_we    <= 1'b0;
            r_seladdr   <= 1'b0;
            r_selacc    <= 2'd0;
            r_selswap   <= 1'b0;
            r_doswap    <= 1'b0;
            r_selip1    <= 1'b0;
            r_selip2    <= 1'b0;
            r_aluinsn   <= 2'd0;
            r_curinsn   <= '0;
            r_halted    <= 1'b0;
            r_illegal   <= 1'b0;
            r_wait_mem  <= 1'b0;
            r_wait_io   <= 1'b0;
            r_xfer      <= 1'b0;
            r_halt_req  <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_mem_read  <= w_mem_read_nx;
            r_mem_write <= w_mem_write_nx;
            r_io_read   <= w_io_read_nx;
            r_io_write  <= w_io_write_nx;
            r_ir_we     <= w_ir_we_nx;
            r_ip_we     <= w_ip_we_nx;
            r_acc_we    <= w_acc_we_nx;
            r_seladdr   <= w_seladdr_nx;
            r_selacc    <= w_selacc_nx;
            r_selswap   <= w_selswap_nx;
            r_doswap    <= w_doswap_nx;
            r_selip1    <= w_selip1_nx;
            r_selip2    <= w_selip2_nx;
            r_aluinsn   <= w_aluinsn_nx;
            r_curinsn   <= w_curinsn_nx;
            r_halted    <= w_halted_nx;
            r_illegal   <= w_illegal_nx;
            r_wait_mem  <= w_wait_mem_nx;
            r_wait_io   <= w_wait_io_nx;
            r_xfer      <= w_xfer_nx;
            r_halt_req  <= w_halt_req_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_FETCH:  if (r_wait_mem && mem_ready) w_state_nx = S_DECODE;
            S_DECODE: w_state_nx = S_EXEC;
            S_EXEC: begin
                if (w_go) begin
                    if (r_halt_req)
                        w_state_nx = S_HALTED;
                    else if (r_xfer || r_curinsn == SLOT_W'(SLOTS - 1))
                        w_state_nx = S_FETCH;
                    else
                        w_state_nx = S_DECODE;
                end
            end
            default:  w_state_nx = S_HALTED;
        endcase
    end

    // Controls are computed for the state being entered and registered on the edge.
    always_comb begin
        w_mem_read_nx  = 1'b0;
        w_mem_write_nx = 1'b0;
        w_io_read_nx   = 1'b0;
        w_io_write_nx  = 1'b0;
        w_ir_we_nx     = 1'b0;
        w_ip_we_nx     = 1'b0;
        w_acc_we_nx    = 1'b0;
        w_seladdr_nx   = 1'b0;
        w_selacc_nx    = 2'd0;
        w_selswap_nx   = 1'b0;
        w_doswap_nx    = 1'b0;
        w_selip1_nx    = 1'b0;
        w_selip2_nx    = 1'b0;
        w_aluinsn_nx   = 2'd0;
        w_curinsn_nx   = r_curinsn;
        w_halted_nx    = 1'b0;
        w_illegal_nx   = 1'b0;
        w_wait_mem_nx  = 1'b0;
        w_wait_io_nx   = 1'b0;
        w_xfer_nx      = 1'b0;
        w_halt_req_nx  = 1'b0;
        case (w_state_nx)
            S_FETCH: begin
                w_mem_read_nx = 1'b1;
                w_ir_we_nx    = 1'b1;
                w_ip_we_nx    = 1'b1;
                w_wait_mem_nx = 1'b1;
                w_curinsn_nx  = '0;
            end
            S_DECODE: begin
                w_curinsn_nx = (r_state == S_FETCH) ? '0 : r_curinsn + SLOT_W'(1);
            end
            S_EXEC: begin
                if (r_state == S_EXEC) begin
                    w_mem_read_nx  = r_mem_read;
                    w_mem_write_nx = r_mem_write;
                    w_io_read_nx   = r_io_read;
                    w_io_write_nx  = r_io_write;
                    w_ip_we_nx     = r_ip_we;
                    w_acc_we_nx    = r_acc_we;
                    w_seladdr_nx   = r_seladdr;
                    w_selacc_nx    = r_selacc;
                    w_selswap_nx   = r_selswap;
                    w_doswap_nx    = r_doswap;
                    w_selip1_nx    = r_selip1;
                    w_selip2_nx    = r_selip2;
                    w_aluinsn_nx   = r_aluinsn;
                    w_wait_mem_nx  = r_wait_mem;
                    w_wait_io_nx   = r_wait_io;
                    w_xfer_nx      = r_xfer;
                    w_halt_req_nx  = r_halt_req;
                end else begin
                    case (insn)
                        OP_NOP: ;
                        OP_SYSCALL: begin
                            case (acc_sys)
                                2'd0: w_halt_req_nx = 1'b1;
                                2'd1: begin
                                    w_io_read_nx = 1'b1;
                                    w_selacc_nx  = 2'd1;
                                    w_acc_we_nx  = 1'b1;
                                    w_wait_io_nx = 1'b1;
                                end
                                2'd2: begin
                                    w_io_write_nx = 1'b1;
                                    w_wait_io_nx  = 1'b1;
                                end
                                default: ;
                            endcase
                        end
                        OP_LOAD, OP_STORE: begin
                            w_mem_read_nx  = (insn == OP_LOAD);
                            w_mem_write_nx = (insn == OP_STORE);
                            w_acc_we_nx    = (insn == OP_LOAD);
                            w_seladdr_nx   = 1'b1;
                            w_wait_mem_nx  = 1'b1;
                        end
                        OP_SWAPA, OP_SWAPD: begin
                            w_selacc_nx  = 2'd2;
                            w_acc_we_nx  = 1'b1;
                            w_doswap_nx  = 1'b1;
                            w_selswap_nx = (insn == OP_SWAPD);
                        end
                        OP_BRANCHZ, OP_BRANCHN: begin
                            if ((insn == OP_BRANCHZ) ? accz : accn) begin
                                w_ip_we_nx  = 1'b1;
                                w_selip1_nx = 1'b1;
                                w_xfer_nx   = 1'b1;
                            end
                        end
                        OP_JUMP: begin
                            w_ip_we_nx  = 1'b1;
                            w_selip1_nx = 1'b1;
                            w_selip2_nx = 1'b1;
                            w_xfer_nx   = 1'b1;
                        end
                        OP_CONST: begin
                            w_mem_read_nx = 1'b1;
                            w_acc_we_nx   = 1'b1;
                            w_ip_we_nx    = 1'b1;
                            w_wait_mem_nx = 1'b1;
                        end
                        OP_ADD, OP_SUB, OP_MUL, OP_DIV: begin
                            w_selacc_nx  = 2'd3;
                            w_acc_we_nx  = 1'b1;
                            w_aluinsn_nx = 2'(insn - OP_ADD);
                        end
                        default: w_illegal_nx = 1'b1;
                    endcase
                end
            end
            default: w_halted_nx = 1'b1;
        endcase
    end

    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;
    assign io_read   = r_io_read;
    assign io_write  = r_io_write;
    assign ir_write  = r_ir_we  && w_go;
    assign ip_write  = r_ip_we  && w_go;
    assign acc_write = r_acc_we && w_go;
    assign seladdr   = r_seladdr;
    assign selacc    = r_selacc;
    assign selswap   = r_selswap;
    assign doswap    = r_doswap;
    assign selip1    = r_selip1;
    assign selip2    = r_selip2;
    assign aluinsn   = r_aluinsn;
    assign curinsn   = r_curinsn;
    assign halted    = r_halted;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_sextium_ctrl_gen.sv
// Bench for sextium_ctrl_gen: a word-level model predicts every cycle of fetch,
// decode and execute from the opcode table, flags and ready latencies.
module tb_sextium_ctrl_gen;

    localparam int unsigned SLOTS_T = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] insn = 4'd0;
    logic       accz = 1'b0, accn = 1'b0;
    logic [1:0] acc_sys = 2'd3;
    logic       mem_ready = 1'b0, io_ready = 1'b0;

    logic mem_read, mem_write, io_read, io_write, ir_write, ip_write, acc_write, seladdr;
    logic [1:0] selacc, aluinsn;
    logic selswap, doswap, selip1, selip2, halted, illegal;
    logic [1:0] curinsn;

    logic mem_read_8, mem_write_8, io_read_8, io_write_8, ir_write_8, ip_write_8, acc_write_8;
    logic seladdr_8, selswap_8, doswap_8, selip1_8, selip2_8, halted_8, illegal_8;
    logic [1:0] selacc_8, aluinsn_8;
    logic [2:0] curinsn_8;

    int n_tests = 0;
    int n_fail  = 0;
    int word[SLOTS_T];

    always #5 clock = ~clock;

    sextium_ctrl_gen dut (
        .clock(clock), .reset(reset), .insn(insn), .accz(accz), .accn(accn),
        .acc_sys(acc_sys), .mem_ready(mem_ready), .io_ready(io_ready),
        .mem_read(mem_read), .mem_write(mem_write), .io_read(io_read), .io_write(io_write),
        .ir_write(ir_write), .ip_write(ip_write), .acc_write(acc_write), .seladdr(seladdr),
        .selacc(selacc), .selswap(selswap), .doswap(doswap), .selip1(selip1),
        .selip2(selip2), .aluinsn(aluinsn), .curinsn(curinsn), .halted(halted),
        .illegal(illegal)
    );

    sextium_ctrl_gen #(.SLOTS(8)) dut8 (
        .clock(clock), .reset(reset), .insn(insn), .accz(accz), .accn(accn),
        .acc_sys(acc_sys), .mem_ready(mem_ready), .io_ready(io_ready),
        .mem_read(mem_read_8), .mem_write(mem_write_8), .io_read(io_read_8),
        .io_write(io_write_8), .ir_write(ir_write_8), .ip_write(ip_write_8),
        .acc_write(acc_write_8), .seladdr(seladdr_8), .selacc(selacc_8),
        .selswap(selswap_8), .doswap(doswap_8), .selip1(selip1_8), .selip2(selip2_8),
        .aluinsn(aluinsn_8), .curinsn(curinsn_8), .halted(halted_8), .illegal(illegal_8)
    );

    logic [17:0] obs;
    assign obs = {mem_read, mem_write, io_read, io_write, ir_write, ip_write, acc_write,
                  seladdr, selacc, selswap, doswap, selip1, selip2, aluinsn, halted, illegal};

    typedef struct packed {
        logic mr, mw, ior, iow, ipw, accw, seladdr;
        logic [1:0] selacc;
        logic selswap, doswap, selip1, selip2;
        logic [1:0] alu;
        logic ill, wmem, wio, xfer, halt;
    } ctl_t;

    // Opcode table: what one executed slot should drive, and how it ends.
    function automatic ctl_t op_ctl(input int op, input bit z, input bit n, input int sys);
        ctl_t e;
        e = '0;
        case (op)
            0: ;
            1: case (sys)
                   0: e.halt = 1'b1;
                   1: begin e.ior = 1'b1; e.selacc = 2'd1; e.accw = 1'b1; e.wio = 1'b1; end
                   2: begin e.iow = 1'b1; e.wio = 1'b1; end
                   default: ;
               endcase
            2: begin e.mr = 1'b1; e.seladdr = 1'b1; e.accw = 1'b1; e.wmem = 1'b1; end
            3: begin e.mw = 1'b1; e.seladdr = 1'b1; e.wmem = 1'b1; end
            4: begin e.selacc = 2'd2; e.accw = 1'b1; e.doswap = 1'b1; end
            5: begin e.selacc = 2'd2; e.accw = 1'b1; e.doswap = 1'b1; e.selswap = 1'b1; end
            6, 7: if ((op == 6) ? z : n) begin e.ipw = 1'b1; e.selip1 = 1'b1; e.xfer = 1'b1; end
            8: begin e.ipw = 1'b1; e.selip1 = 1'b1; e.selip2 = 1'b1; e.xfer = 1'b1; end
            9: begin e.mr = 1'b1; e.accw = 1'b1; e.ipw = 1'b1; e.wmem = 1'b1; end
            10, 11, 12, 13: begin e.selacc = 2'd3; e.accw = 1'b1; e.alu = 2'(op - 10); end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    task automatic do_reset;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    // Runs one fetched word through the model, checking every cycle.
    task automatic run_word(input string tag, input bit z, input bit n, input int sys,
                            input int dly, output int ncyc);
        ctl_t e;
        logic [17:0] exp;
        bit rdy;
        int d;
        ncyc = 0;
        accz = z; accn = n; acc_sys = 2'(sys);
        for (int c = 0; c <= dly; c++) begin
            @(negedge clock);
            rdy = (c == dly);
            mem_ready = rdy; io_ready = 1'($urandom);
            #1; ncyc++;
            exp = {1'b1, 3'b000, rdy, rdy, 1'b0, 11'd0};
            n_tests++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL %s fetch c%0d: got %b want %b", tag, c, obs, exp);
            end
        end
        for (int s = 0; s < int'(SLOTS_T); s++) begin
            e = op_ctl(word[s], z, n, sys);
            d = (e.wmem || e.wio) ? dly : 0;
            @(negedge clock);
            insn = 4'(word[s]); mem_ready = 1'($urandom); io_ready = 1'($urandom);
            #1; ncyc++;
            n_tests++;
            if (obs !== 18'd0 || curinsn !== 2'(s)) begin
                n_fail++;
                $display("FAIL %s decode s%0d: got %b slot %0d want 0 slot %0d", tag, s, obs, curinsn, s);
            end
            for (int c = 0; c <= d; c++) begin
                @(negedge clock);
                rdy = (c == d);
                mem_ready = e.wmem ? rdy : 1'($urandom);
                io_ready  = e.wio  ? rdy : 1'($urandom);
                #1; ncyc++;
                exp = {e.mr, e.mw, e.ior, e.iow, 1'b0, e.ipw & rdy, e.accw & rdy, e.seladdr,
                       e.selacc, e.selswap, e.doswap, e.selip1, e.selip2, e.alu, 1'b0,
                       e.ill & (c == 0)};
                n_tests++;
                if (obs !== exp || curinsn !== 2'(s)) begin
                    n_fail++;
                    $display("FAIL %s exec s%0d c%0d op%0d: got %b slot %0d want %b slot %0d",
                             tag, s, c, word[s], obs, curinsn, exp, s);
                end
            end
            if (e.halt) begin
                for (int c = 0; c < 4; c++) begin
                    @(negedge clock);
                    mem_ready = 1'($urandom); io_ready = 1'($urandom);
                    #1;
                    n_tests++;
                    if (obs !== 18'b10) begin
                        n_fail++;
                        $display("FAIL %s halted c%0d: got %b want %b", tag, c, obs, 18'b10);
                    end
                end
                break;
            end
            if (e.xfer) break;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; mem_ready = 1'b1; io_ready = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        n_tests++;
        if (obs !== 18'd0 || curinsn !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %b slot %0d want 0 slot 0", obs, curinsn);
        end
        reset = 1'b1; mem_ready = 1'b0;
        @(negedge clock);
        #1;
        n_tests++;
        if (obs !== {1'b1, 17'd0} || curinsn !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_to_fetch: got %b want %b", obs, {1'b1, 17'd0});
        end
    endtask

    task automatic test_nop_word;
        int nc;
        word = '{0, 0, 0, 0};
        for (int k = 0; k < 2; k++) begin
            run_word("nop_word", 1'b0, 1'b0, 3, 0, nc);
            n_tests++;
            if (nc !== 9) begin
                n_fail++;
                $display("FAIL nop_word_period: got %0d cycles want 9", nc);
            end
        end
    endtask

    task automatic test_load_wait;
        int nc;
        word = '{2, 3, 9, 0};
        run_word("load_wait", 1'b0, 1'b0, 3, 3, nc);
        n_tests++;
        if (nc !== 4 + 5 + 5 + 5 + 2) begin
            n_fail++;
            $display("FAIL load_wait_cycles: got %0d want %0d", nc, 21);
        end
    endtask

    task automatic test_branch;
        int nc;
        word = '{0, 6, 0, 2};
        run_word("branchz_taken", 1'b1, 1'b0, 3, 1, nc);
        n_tests++;
        if (nc !== 6) begin
            n_fail++;
            $display("FAIL branchz_taken_cycles: got %0d want 6", nc);
        end
        run_word("branchz_not_taken", 1'b0, 1'b1, 3, 1, nc);
        n_tests++;
        if (nc !== 11) begin
            n_fail++;
            $display("FAIL branchz_not_taken_cycles: got %0d want 11", nc);
        end
        word = '{7, 8, 0, 0};
        run_word("branchn_taken", 1'b0, 1'b1, 3, 0, nc);
        run_word("jump", 1'b0, 1'b0, 3, 0, nc);
    endtask

    task automatic test_syscall;
        int nc;
        word = '{1, 4, 5, 0};
        run_word("sys_read", 1'b0, 1'b0, 1, 2, nc);
        n_tests++;
        if (nc !== 3 + 4 + 6) begin
            n_fail++;
            $display("FAIL sys_read_cycles: got %0d want 13", nc);
        end
        run_word("sys_write", 1'b0, 1'b0, 2, 1, nc);
        run_word("sys_nop", 1'b0, 1'b0, 3, 0, nc);
        word = '{0, 1, 0, 0};
        run_word("sys_halt", 1'b0, 1'b0, 0, 0, nc);
        do_reset();
    endtask

    task automatic test_illegal;
        int nc;
        word = '{15, 14, 10, 13};
        run_word("illegal", 1'b0, 1'b0, 3, 0, nc);
        n_tests++;
        if (nc !== 9) begin
            n_fail++;
            $display("FAIL illegal_cycles: got %0d want 9", nc);
        end
    endtask

    task automatic test_random;
        int nc;
        for (int w = 0; w < 24; w++) begin
            for (int s = 0; s < int'(SLOTS_T); s++) word[s] = int'($urandom_range(0, 15));
            run_word("random", 1'($urandom), 1'($urandom), int'($urandom_range(1, 3)),
                     int'($urandom_range(0, 3)), nc);
        end
    endtask

    task automatic test_reset_mid_wait;
        do_reset();
        @(negedge clock); mem_ready = 1'b1; #1;
        @(negedge clock); insn = 4'd2; mem_ready = 1'b0;
        @(negedge clock); mem_ready = 1'b0; #1;
        n_tests++;
        if (mem_read !== 1'b1 || seladdr !== 1'b1 || acc_write !== 1'b0) begin
            n_fail++;
            $display("FAIL midwait_load: got rd %b addr %b accw %b want 1 1 0", mem_read, seladdr, acc_write);
        end
        @(negedge clock); reset = 1'b0;
        @(negedge clock); #1;
        n_tests++;
        if (obs !== 18'd0 || curinsn !== 2'd0) begin
            n_fail++;
            $display("FAIL midwait_reset: got %b slot %0d want 0 slot 0", obs, curinsn);
        end
        reset = 1'b1;
        @(negedge clock); #1;
        n_tests++;
        if (obs !== {1'b1, 17'd0} || curinsn !== 2'd0) begin
            n_fail++;
            $display("FAIL midwait_refetch: got %b want %b", obs, {1'b1, 17'd0});
        end
    endtask

    task automatic test_slots8;
        int q4[$];
        int q8[$];
        int max8;
        max8 = 0;
        insn = 4'd0; accz = 1'b0; accn = 1'b0; acc_sys = 2'd3;
        mem_ready = 1'b1; io_ready = 1'b1;
        do_reset();
        for (int c = 0; c < 60; c++) begin
            @(negedge clock); #1;
            if (ir_write)   q4.push_back(c);
            if (ir_write_8) q8.push_back(c);
            if (int'(curinsn_8) > max8) max8 = int'(curinsn_8);
        end
        n_tests++;
        if (q8.size() < 3 || q8[1] - q8[0] != 17 || q8[2] - q8[1] != 17) begin
            n_fail++;
            $display("FAIL slots8_period: got %0d fetches, first gap %0d want gaps of 17",
                     q8.size(), (q8.size() >= 2) ? q8[1] - q8[0] : -1);
        end
        n_tests++;
        if (max8 != 7) begin
            n_fail++;
            $display("FAIL slots8_last_slot: got %0d want 7", max8);
        end
        n_tests++;
        if (q4.size() < 3 || q4[1] - q4[0] != 9 || q4[2] - q4[1] != 9) begin
            n_fail++;
            $display("FAIL slots4_period: got %0d fetches want gaps of 9", q4.size());
        end
        mem_ready = 1'b0; io_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_nop_word();
        test_load_wait();
        test_branch();
        test_syscall();
        test_illegal();
        test_random();
        test_reset_mid_wait();
        test_slots8();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sextium_ctrl_gen.md
Name: sextium_ctrl_gen

Overview:
Parametrised next-generation Sextium III control unit. It fetches one instruction word of SLOTS packed INSN_W-bit opcodes and sequences them slot by slot. It drives the same datapath mux/strobe set as the current controller, and adds three things: memory and IO ready handshakes, SYSCALL IO modes, and early refetch on a taken control transfer. It sits between the instruction register / accumulator flags and the datapath / memory / IO ports.

Parameters:
SLOTS, 4, opcodes per fetched word (power of two, at least 2); slot 0 executes first.
SLOT_W, $clog2(SLOTS), width of the slot index.
INSN_W, 4, opcode width; opcodes 0-13 are defined, all other codes are illegal.

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-low; sampled on rising edge
insn  in  INSN_W  opcode of current slot (datapath selects by curinsn)
accz  in  1  accumulator == 0
accn  in  1  accumulator < 0
acc_sys  in  2  acc[1:0], SYSCALL service code
mem_ready  in  1  memory completes the pending access this cycle
io_ready  in  1  IO completes the pending transfer this cycle
mem_read, mem_write  out  1  memory strobes, held until mem_ready
io_read, io_write  out  1  IO strobes, held until io_ready
ir_write, ip_write, acc_write  out  1  register write enables
seladdr  out  1  0=IP, 1=AR
selacc  out  2  0=MEM, 1=IO, 2=SWAP, 3=ALU
selswap  out  1  0=AR, 1=DR
doswap  out  1  swap-register write
selip1  out  1  0=IP+1, 1=register
selip2  out  1  0=AR, 1=ACC
aluinsn  out  2  0=ADD, 1=SUB, 2=MUL, 3=DIV
curinsn  out  SLOT_W  slot index
halted  out  1  high while in HALTED
illegal  out  1  one-cycle pulse on illegal opcode

Behaviour:
- Opcodes: 0 NOP, 1 SYSCALL, 2 LOAD, 3 STORE, 4 SWAPA, 5 SWAPD, 6 BRANCHZ, 7 BRANCHN, 8 JUMP, 9 CONST, 10 ADD, 11 SUB, 12 MUL, 13 DIV.
- States: FETCH, DECODE, EXEC, HALTED. Selects and strobes are registered.
- Ready-gated enables: ir_write, ip_write and acc_write are combinational ANDs of the registered enable with the relevant ready, so each fires exactly once per access.
- Reset (reset=0 at a rising edge): state=FETCH, curinsn=0, all strobes/enables=0, every select=0, aluinsn=0, halted=0, illegal=0. A reset mid-wait abandons the access and deasserts strobes next cycle.
- FETCH: mem_read=1, seladdr=IP, selip1=NEXT. ir_write and ip_write are high only in the cycle mem_ready=1; that cycle moves to DECODE with curinsn=0. Otherwise stay in FETCH.
- DECODE (1 cycle): register the controls for insn, then go to EXEC.
- EXEC control by opcode:
  - LOAD: mem_read, seladdr=AR, selacc=MEM, acc_write on mem_ready.
  - STORE: mem_write, seladdr=AR.
  - CONST: mem_read, seladdr=IP, selacc=MEM; acc_write and ip_write (NEXT) on mem_ready.
  - SWAPA/SWAPD: selacc=SWAP, acc_write, doswap, selswap=AR or DR.
  - ALU ops: selacc=ALU, aluinsn=opcode-10, acc_write.
  - BRANCHZ/BRANCHN: ip_write with selip1=REG, selip2=AR, only if accz/accn.
  - JUMP: ip_write, selip1=REG, selip2=ACC.
  - SYSCALL on acc_sys: 0 -> HALTED; 1 -> io_read, selacc=IO, acc_write on io_ready; 2 -> io_write, done on io_ready; 3 -> NOP.
- EXEC wait: memory/IO ops stay in EXEC until their ready; all other ops take 1 cycle.
- EXEC exit: on completion, all strobes drop next cycle. Go to FETCH (curinsn to 0) if curinsn==SLOTS-1 or a JUMP/taken branch executed. Otherwise curinsn+1 and go to DECODE.
- Wrap-around: curinsn never wraps by itself.
- Illegal opcode: illegal pulses in the DECODE->EXEC cycle; the slot executes as NOP.
- HALTED: all strobes 0, halted=1; exit only via reset.
- Ready asserted outside a wait state is ignored.

Test Plan:
- Readies tied high, word of 4 NOPs -> FETCH 1 cycle, then 4x(DECODE+EXEC); refetch at cycle 9; curinsn 0,1,2,3,0.
- LOAD with mem_ready low 3 cycles -> mem_read and seladdr=AR held 4 EXEC cycles; acc_write exactly 1 cycle, coincident with mem_ready.
- BRANCHZ in slot 1 with accz=1 -> ip_write selip2=AR for 1 cycle; slots 2-3 skipped; next state FETCH. Same with accz=0 -> slot 2 executes.
- SYSCALL acc_sys=1, io_ready after 2 cycles -> io_read 3 cycles, selacc=1, 1-cycle acc_write. acc_sys=0 -> halted=1 permanently, strobes 0.
- Opcode 15 -> illegal pulses 1 cycle, no strobes, next slot proceeds. SLOTS=8 build -> 8 slots per fetch before refetch.
- reset=0 during a LOAD wait -> next cycle all strobes 0, state FETCH, curinsn=0.
